upsample_scheduler: RTL and testbench
=====================================

UPSAMPLE_SCHEDULER -- requirements
Module: upsample_scheduler

Interface
REQ-001 SHALL have parameter: none; ratio is runtime via n_log2.
REQ-002 SHALL have port: clk  in  1  single system clock, all logic rising-edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: enable  in  1  start/continue streaming.
REQ-005 SHALL have port: n_log2  in  3  upsample ratio exponent, N = 2^n_log2.
REQ-006 SHALL have port: fifo_empty  in  1  ADC FIFO empty flag.
REQ-007 SHALL have port: fifo_rdata  in  32  FIFO word: [31:16] left, [15:0] right, signed.
REQ-008 SHALL have port: fifo_rdreq  out  1  one-cycle FIFO pop strobe.
REQ-009 SHALL have port: out_tick  in  1  one-cycle strobe at output sample rate.
REQ-010 SHALL have port: underrun_clr  in  1  clears sticky underrun.
REQ-011 SHALL have port: out_data  out  32  {left, right} interpolated sample.
REQ-012 SHALL have port: out_valid  out  1  out_data valid strobe.
REQ-013 SHALL have port: phase  out  5  current interpolation index k.
REQ-014 SHALL have port: underrun  out  1  sticky FIFO-starvation flag.
REQ-015 SHALL have port: busy  out  1  high in any state except IDLE.

Function
REQ-016 SHALL implement states IDLE, FETCH, LATCH, RUN, STARVE.
REQ-017 IDLE: enable=1 and fifo_empty=0 -> FETCH; n_log2 sampled here only; values >5 SHALL clamp to 5.
REQ-018 FETCH: fifo_rdreq=1 for exactly one cycle -> LATCH (FIFO is non-showahead, data valid next cycle).
REQ-019 LATCH (prime): prev<=fifo_rdata, cur<=fifo_rdata, k<=0 -> RUN.
REQ-020 RUN: on out_tick, out_data = prev + ((cur-prev)*k >>> n_log2) per channel, out_valid one cycle after out_tick, then k<=k+1.
REQ-021 Arithmetic: diff 17-bit signed, product 22-bit signed, arithmetic shift (round toward -inf), result truncated to 16 bits (always lies between prev and cur).
REQ-022 Segment end: on out_tick with k=N-1, if enable=0 -> IDLE after emitting; else if fifo_empty=0 assert fifo_rdreq same cycle, next cycle prev<=cur, cur<=fifo_rdata, k<=0, stay RUN.
REQ-023 Segment end with enable=1 and fifo_empty=1 -> STARVE, underrun<=1.
REQ-024 STARVE: each out_tick emits out_data={cur} both channels with out_valid; when fifo_empty=0, pop (rdreq), next cycle prev<=cur, cur<=rdata, k<=0 -> RUN.
REQ-025 N=1 (n_log2=0): every out_tick is a segment end; output equals prev.
REQ-026 out_tick outside RUN/STARVE SHALL be ignored; out_tick spacing shall be >=3 cycles (guaranteed by source).
REQ-027 underrun set and underrun_clr in same cycle: set wins.
REQ-028 fifo_rdreq SHALL never assert while fifo_empty=1.
REQ-029 phase SHALL equal k; out_data holds last value between strobes.

Reset
REQ-030 reset SHALL force IDLE, fifo_rdreq=0, out_valid=0, out_data=0, phase=0, underrun=0, busy=0, prev=cur=0, latched N=1.
REQ-031 reset mid-RUN/STARVE SHALL abort immediately; any in-flight FIFO word is discarded.

Structure
REQ-032 Shared package SHALL hold state enum, MAX_LOG2=5, SAMPLE_W=16, WORD_W=32.
REQ-033 One sub-module interp_lane (prev, cur, k, n_log2 -> 16-bit result), instantiated for left and right.

Verification
REQ-034 Prime: FIFO {0x0000,0x0000} then {0x0100,0xFF00}, n_log2=2 -> outputs 4x{0,0}, then left 0x0000,0x0040,0x0080,0x00C0, right 0x0000,0xFFC0,0xFF80,0xFF40.
REQ-035 Negative slope/rounding: prev left=0x0003, cur=0x0000, n_log2=1 -> k=1 output 0x0001 (floor of 1.5).
REQ-036 Starvation: FIFO empties at segment end -> underrun=1, out_data repeats cur on every tick, no rdreq; refill -> single rdreq, resume at k=0 from cur.
REQ-037 n_log2=7 -> clamped, 32 outputs per input sample, phase wraps 31->0.
REQ-038 enable drop mid-segment -> remaining phases emitted, IDLE after k=N-1, no extra pop.
REQ-039 reset asserted in LATCH and underrun_clr concurrent with set -> all outputs 0 after reset; underrun stays 1 in clr/set collision.

Source files
------------

// File: rtl/upsample_scheduler_pkg.sv
// Shared types and constants for the stereo upsample scheduler.
// Holds the scheduler state encoding, sample layout and phase helpers.
package upsample_scheduler_pkg;

  localparam int MAX_LOG2 = 5;
  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    RUN,
    STARVE
  } state_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } sample_t;

  function automatic logic [2:0] clamp_log2(input logic [2:0] n);
    return (n > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : n;
  endfunction

  // Last interpolation index of a segment, N-1 with N = 2^n.
  function automatic logic [4:0] last_phase(input logic [2:0] n);
    logic [5:0] span;
    span = 6'd1 << n;
    return 5'(span - 6'd1);
  endfunction

endpackage

// File: rtl/interp_lane.sv
// One channel of linear interpolation: prev + ((cur - prev) * k >>> n_log2).
// Purely combinational; the floor shift keeps the result between prev and cur.
module interp_lane
  import upsample_scheduler_pkg::*;
(
  input  logic [SAMPLE_W-1:0] prev,
  input  logic [SAMPLE_W-1:0] cur,
  input  logic [4:0]          k,
  input  logic [2:0]          n_log2,
  output logic [SAMPLE_W-1:0] result
);

  logic signed [16:0] diff;
  logic signed [21:0] diff_x;
  logic signed [21:0] k_x;
  logic signed [21:0] prod;

  assign diff   = $signed({cur[15], cur}) - $signed({prev[15], prev});
  assign diff_x = 22'(diff);
  assign k_x    = $signed({17'd0, k});
  assign prod   = diff_x * k_x;
  assign result = prev + 16'(prod >>> n_log2);

endmodule

// File: rtl/upsample_scheduler.sv
// Pops stereo words from a non-showahead FIFO and emits 2^n_log2 interpolated samples per word.
// Output lands one cycle after out_tick; FIFO starvation repeats the current word and sets underrun.
module upsample_scheduler
  import upsample_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        n_log2,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_rdata,
  output logic              fifo_rdreq,
  input  logic              out_tick,
  input  logic              underrun_clr,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic [4:0]        phase,
  output logic              underrun,
  output logic              busy
);

  state_t              state, state_nx;
  sample_t             prev, cur, rdata;
  logic [2:0]          n_lat;
  logic [4:0]          k;
  logic                reload;
  logic                seg_end;
  logic [SAMPLE_W-1:0] lerp_l, lerp_r;

  assign rdata   = sample_t'(fifo_rdata);
  assign seg_end = out_tick && !reload && (k == last_phase(n_lat));
  assign busy    = (state != IDLE);
  assign phase   = k;

  interp_lane u_lane_l (
    .prev   (prev.left),
    .cur    (cur.left),
    .k      (k),
    .n_log2 (n_lat),
    .result (lerp_l)
  );

  interp_lane u_lane_r (
    .prev   (prev.right),
    .cur    (cur.right),
    .k      (k),
    .n_log2 (n_lat),
    .result (lerp_r)
  );

  always_comb begin
    state_nx   = state;
    fifo_rdreq = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !fifo_empty) state_nx = FETCH;
      end
      FETCH: begin
        if (!fifo_empty) begin
          fifo_rdreq = 1'b1;
          state_nx   = LATCH;
        end
      end
      LATCH: state_nx = RUN;
      RUN: begin
        if (seg_end) begin
          if (!enable)          state_nx = IDLE;
          else if (!fifo_empty) fifo_rdreq = 1'b1;
          else                  state_nx = STARVE;
        end
      end
      STARVE: begin
        if (!fifo_empty) begin
          fifo_rdreq = 1'b1;
          state_nx   = RUN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prev      <= '0;
      cur       <= '0;
      k         <= '0;
      n_lat     <= '0;
      reload    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= 1'b0;
      // A pop from RUN/STARVE lands its word one cycle later, shifting the segment.
      reload    <= fifo_rdreq && (state == RUN || state == STARVE);
      if (underrun_clr) underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (state_nx == FETCH) n_lat <= clamp_log2(n_log2);
        end
        LATCH: begin
          prev <= rdata;
          cur  <= rdata;
          k    <= '0;
        end
        RUN: begin
          if (reload) begin
            prev <= cur;
            cur  <= rdata;
            k    <= '0;
          end else if (out_tick) begin
            out_data  <= {lerp_l, lerp_r};
            out_valid <= 1'b1;
            k         <= seg_end ? 5'd0 : k + 5'd1;
            if (seg_end && enable && fifo_empty) underrun <= 1'b1;
          end
        end
        STARVE: begin
          if (out_tick) begin
            out_data  <= cur;
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_upsample_scheduler.sv
// Randomized and directed bench for upsample_scheduler against an arithmetic reference model.
module tb_upsample_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  n_log2;
  logic        fifo_empty;
  logic [31:0] fifo_rdata;
  logic        fifo_rdreq;
  logic        out_tick;
  logic        underrun_clr;
  logic [31:0] out_data;
  logic        out_valid;
  logic [4:0]  phase;
  logic        underrun;
  logic        busy;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  ph;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fq[$];
  logic [31:0] seen[$];
  logic [31:0] stim[$];
  logic [31:0] c034[4];
  int          pops;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  upsample_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .n_log2       (n_log2),
    .fifo_empty   (fifo_empty),
    .fifo_rdata   (fifo_rdata),
    .fifo_rdreq   (fifo_rdreq),
    .out_tick     (out_tick),
    .underrun_clr (underrun_clr),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .phase        (phase),
    .underrun     (underrun),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, req);
    end
  endtask

  // Exact rational interpolation, floored: prev + floor((cur-prev)*k / N).
  function automatic logic [15:0] lane_ref(input logic [15:0] p, input logic [15:0] c,
                                           input int n, input int k);
    int pv, cv, num, den, q;
    pv  = int'($signed(p));
    cv  = int'($signed(c));
    den = 1 << n;
    num = (cv - pv) * k;
    q   = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return 16'(pv + q);
  endfunction

  task automatic push_seg(input logic [31:0] p, input logic [31:0] c, input int n);
    exp_t e;
    int   big_n;
    big_n = 1 << n;
    for (int k = 0; k < big_n; k++) begin
      e.d  = {lane_ref(p[31:16], c[31:16], n, k), lane_ref(p[15:0], c[15:0], n, k)};
      e.ph = 5'((k + 1) % big_n);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_hold(input logic [31:0] c);
    exp_t e;
    e.d  = c;
    e.ph = 5'd0;
    exp_q.push_back(e);
  endtask

  // One clock: drive at posedge+1, serve pops at negedge, sample outputs at next posedge+1.
  task automatic cyc(input logic tick, input logic clr);
    logic [31:0] w;
    logic        got;
    exp_t        e;
    got          = 1'b0;
    w            = '0;
    out_tick     = tick;
    underrun_clr = clr;
    fifo_empty   = (fq.size() == 0);
    @(negedge clk);
    if (fifo_rdreq) begin
      chk("rdreq_while_empty", 32'(fifo_empty), 32'd0);
      if (fq.size() != 0) begin
        w   = fq.pop_front();
        got = 1'b1;
        pops++;
      end
    end
    @(posedge clk);
    #1;
    out_tick     = 1'b0;
    underrun_clr = 1'b0;
    if (got) fifo_rdata = w;
    if (out_valid) begin
      seen.push_back(out_data);
      if (exp_q.size() == 0) chk("spurious_valid", 32'(out_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.d);
        chk("phase", 32'(phase), 32'(e.ph));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0);
  endtask

  task automatic tk(input logic clr);
    cyc(1'b1, clr);
    idle($urandom_range(2, 4));
  endtask

  // Streams stim[] with an extra word left in the FIFO; enable drops inside the last segment.
  task automatic run_stream(input logic [2:0] n_in);
    int nn, nt, m;
    nn = (n_in > 3'd5) ? 5 : int'(n_in);
    m  = stim.size();
    nt = m << nn;
    seen.delete();
    pops = 0;
    push_seg(stim[0], stim[0], nn);
    for (int j = 1; j < m; j++) push_seg(stim[j-1], stim[j], nn);
    fq = stim;
    fq.push_back(32'hDEAD_BEEF);
    n_log2 = n_in;
    enable = 1'b1;
    cyc(1'b0, 1'b0);
    n_log2 = 3'($urandom);
    idle(3);
    for (int t = 0; t < nt; t++) begin
      if (t == nt - (1 << nn)) enable = 1'b0;
      tk(1'b0);
    end
    idle(3);
    chk("stream_missing", 32'(exp_q.size()), 32'd0);
    chk("stream_busy", 32'(busy), 32'd0);
    chk("stream_pops", 32'(pops), 32'(m));
    chk("stream_underrun", 32'(underrun), 32'd0);
    tk(1'b0);
    fq.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] w0, w1, w2;
    reset = 1'b1; enable = 1'b0; n_log2 = '0; fifo_empty = 1'b1;
    fifo_rdata = '0; out_tick = 1'b0; underrun_clr = 1'b0;
    c034 = '{32'h0000_0000, 32'h0040_FFC0, 32'h0080_FF80, 32'h00C0_FF40};
    idle(3);
    reset = 1'b0;
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdreq", 32'(fifo_rdreq), 32'd0);

    // Ramp from zero, N=4
    stim = '{32'h0000_0000, 32'h0100_FF00};
    run_stream(3'd2);
    chk("p034_count", 32'(seen.size()), 32'd8);
    for (int i = 0; i < 4; i++)
      if (4 + i < seen.size()) chk("p034_value", seen[4+i], c034[i]);

    // Negative slope floors toward -inf
    stim = '{32'h0003_0000, 32'h0000_0000};
    run_stream(3'd1);
    if (seen.size() > 3) chk("p035_floor", 32'(seen[3][31:16]), 32'h0001);
    else chk("p035_count", 32'(seen.size()), 32'd4);

    for (int it = 0; it < 6; it++) begin
      stim.delete();
      for (int j = 0; j < int'($urandom_range(2, 4)); j++) stim.push_back($urandom);
      run_stream(3'($urandom_range(0, 5)));
    end

    // Out-of-range exponent clamps to 32 phases
    stim = '{$urandom, $urandom};
    run_stream(3'd7);
    chk("clamp_count", 32'(seen.size()), 32'd64);

    // Starvation, with clear colliding with the set
    w0 = $urandom; w1 = $urandom; w2 = $urandom;
    fq = '{w0, w1};
    pops = 0;
    push_seg(w0, w0, 1);
    push_seg(w0, w1, 1);
    repeat (3) push_hold(w1);
    push_seg(w1, w2, 1);
    n_log2 = 3'd1;
    enable = 1'b1;
    idle(4);
    tk(1'b0); tk(1'b0); tk(1'b0); tk(1'b1);
    chk("underrun_set_wins", 32'(underrun), 32'd1);
    chk("starve_pops", 32'(pops), 32'd2);
    repeat (3) tk(1'b0);
    chk("starve_no_pop", 32'(pops), 32'd2);
    chk("starve_busy", 32'(busy), 32'd1);
    fq.push_back(w2);
    idle(3);
    chk("refill_single_pop", 32'(pops), 32'd3);
    tk(1'b0);
    enable = 1'b0;
    tk(1'b0);
    idle(3);
    chk("refill_busy", 32'(busy), 32'd0);
    chk("refill_missing", 32'(exp_q.size()), 32'd0);

    // Reset while the first word is being latched
    fq = '{32'h1234_5678, 32'h9ABC_DEF0};
    pops = 0;
    n_log2 = 3'd2;
    enable = 1'b1;
    for (int i = 0; i < 10 && pops == 0; i++) idle(1);
    chk("latch_pop", 32'(pops), 32'd1);
    enable = 1'b0;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("latch_rst_data", out_data, 32'd0);
    chk("latch_rst_valid", 32'(out_valid), 32'd0);
    chk("latch_rst_phase", 32'(phase), 32'd0);
    chk("latch_rst_underrun", 32'(underrun), 32'd0);
    chk("latch_rst_busy", 32'(busy), 32'd0);
    chk("latch_rst_rdreq", 32'(fifo_rdreq), 32'd0);
    idle(3);
    chk("latch_rst_stays_idle", 32'(busy), 32'd0);
    fq.delete();

    // N=1 starvation, plain clear, then reset out of STARVE
    w0 = $urandom;
    fq = '{w0};
    push_seg(w0, w0, 0);
    push_hold(w0);
    n_log2 = 3'd0;
    enable = 1'b1;
    idle(4);
    tk(1'b0);
    chk("n1_underrun", 32'(underrun), 32'd1);
    tk(1'b0);
    cyc(1'b0, 1'b1);
    chk("underrun_clr", 32'(underrun), 32'd0);
    enable = 1'b0;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("starve_rst_busy", 32'(busy), 32'd0);
    chk("starve_rst_data", out_data, 32'd0);
    chk("n1_missing", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
